// File: rtl/stoch_bitgen.sv
// -----------------------------------------------------------------------------
// stoch_bitgen
//   Turns one quota value (number of ones wanted in a BITSTREAM-long stochastic
//   stream) into a serial BITSTREAM-bit stream carrying exactly that many ones.
//   The stream is emitted one bit per accepted output beat.
//
//   Default mode: ones are spread with a Bresenham/Weyl accumulator, so the
//   stream is low-discrepancy (ones are as evenly spaced as the quota allows).
//
//   Optional mode (define STOCH_BITGEN_UNARY_EN): thermometer coding, the first
//   'quota' bits are 1 and the rest 0. The accumulator is not built.
//   Handshake, latency, out_last and quota saturation are the same in both modes.
//
// Parameters
//   BITSTREAM  stream length T in bits (>= 2, power of two)
//   QW         quota width, $clog2(T)+1, so full scale T is representable
//   IW         bit index width, $clog2(T)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous, active-high reset
//   in_valid   quota_in is valid
//   in_ready   block can accept a quota this cycle
//   quota_in   requested ones count; values above T saturate to T
//   out_valid  out_bit is valid
//   out_ready  consumer accepts out_bit this cycle
//   out_bit    current stream bit
//   out_last   marks bit index T-1 of the stream
//   out_idx    index of the current bit within the stream
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   The output side holds out_bit/out_last/out_idx stable while out_valid=1 and
//   out_ready=0. in_ready is high in IDLE, and in RUN only on the last beat when
//   the consumer takes it (in_ready = IDLE | (RUN & out_last & out_ready)), so
//   in_ready depends combinationally on out_ready. A quota accepted on the last
//   beat starts the next stream on the following cycle with no bubble. An
//   upstream producer presenting in_valid earlier in RUN simply waits.
// -----------------------------------------------------------------------------
module stoch_bitgen #(
  parameter  int BITSTREAM = 64,
  localparam int QW        = $clog2(BITSTREAM) + 1,
  localparam int IW        = $clog2(BITSTREAM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] quota_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [IW-1:0] out_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [QW-1:0] T_Q      = QW'(BITSTREAM);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITSTREAM - 1);

  state_t        state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          run;
  logic          accept;
  logic          beat;
  logic          bit_raw;
  logic [QW-1:0] quota_sat;

  // ---------------------------------------------------------------------------
  // Bit decode
  // ---------------------------------------------------------------------------
`ifdef STOCH_BITGEN_UNARY_EN
  // Thermometer: index zero-extended to quota width so idx < T compares
  // correctly against a full-scale quota of T.
  always_comb begin
    bit_raw = ({1'b0, idx_q} < q_q);
  end
`else
  // Weyl accumulator: acc stays in [0, T). Each beat adds q; crossing T emits a
  // one and wraps. After T beats exactly q ones have been emitted and acc is
  // back at 0. The sum is one bit wider than the quota so acc + q (< 2T) never
  // overflows.
  localparam logic [QW:0] T_S = (QW + 1)'(BITSTREAM);

  logic [QW:0] acc_q, acc_d;
  logic [QW:0] sum;

  always_comb begin
    sum     = acc_q + {1'b0, q_q};
    bit_raw = (sum >= T_S);
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (beat) begin
      acc_d = bit_raw ? (sum - T_S) : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    run       = (state_q == RUN);
    out_valid = run;
    out_last  = run && (idx_q == IDX_LAST);
    out_idx   = run ? idx_q : '0;
    out_bit   = run && bit_raw;
    // Reload on the last beat keeps streams back-to-back.
    in_ready  = !run || (out_last && out_ready);
    accept    = in_valid && in_ready;
    beat      = out_valid && out_ready;
    quota_sat = (quota_in > T_Q) ? T_Q : quota_in;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          q_d     = quota_sat;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // Only possible on the last beat: start the next stream directly.
          q_d   = quota_sat;
          idx_d = '0;
        end else if (beat) begin
          // idx wraps to 0 after T-1 because T is a power of two.
          idx_d = idx_q + IW'(1);
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Embedded invariants
  // ---------------------------------------------------------------------------
  // A stalled beat keeps every output stable on the next cycle.
  stall_hold_a: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_bit) && $stable(out_idx) && $stable(out_last)));

  // Quota register never exceeds full scale.
  quota_range_a: assert property (@(posedge clk) disable iff (rst)
    (q_q <= T_Q));

`ifndef STOCH_BITGEN_UNARY_EN
  // Accumulator stays strictly below T.
  acc_range_a: assert property (@(posedge clk) disable iff (rst)
    (acc_q < T_S));
`endif

endmodule

// File: tb/tb_stoch_bitgen.sv
// -----------------------------------------------------------------------------
// tb_stoch_bitgen
//   Directed bench for stoch_bitgen with T=64. Each stream is checked beat by
//   beat against a reference bit model, plus hand-computed totals (ones count,
//   index of first one). Build with +define+STOCH_BITGEN_UNARY_EN on both files
//   for the thermometer-mode run.
// -----------------------------------------------------------------------------
module tb_stoch_bitgen;

  localparam int T  = 64;
  localparam int QW = 7;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] quota_in;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic [IW-1:0] out_idx;

  int errors = 0;
  int checks = 0;

  stoch_bitgen #(.BITSTREAM(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quota_in  (quota_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit i of a stream with k ones (k already saturated to T).
  function automatic bit exp_bit(input int k, input int i);
`ifdef STOCH_BITGEN_UNARY_EN
    return (i < k);
`else
    // Ideal evenly spaced ones: a one wherever floor(n*k/T) steps up.
    return (((i + 1) * k) / T) != ((i * k) / T);
`endif
  endfunction

  // Expected first-one index: hand-computed Bresenham value, or 0 for
  // thermometer mode (any non-zero quota starts with a one).
  function automatic int exp_first(input int bres, input int k);
`ifdef STOCH_BITGEN_UNARY_EN
    return (k > 0) ? 0 : -1;
`else
    return bres;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a quota while IDLE; first beat must be valid one cycle later.
  task automatic send_quota(input int q);
    in_valid = 1'b1;
    quota_in = QW'(q);
    #1;
    check_eq("idle_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("first_beat_valid", out_valid, 1);
    check_eq("first_beat_idx", out_idx, 0);
  endtask

  // Consume one full stream. With has_next, the next quota is held on the
  // input for the whole stream and must be taken on the last beat only.
  task automatic collect(input int k, input bit rand_ready, input bit has_next,
                         input int next_q, output int ones, output int first);
    int            beats;
    int            cycles;
    bit            stalled;
    logic          sb;
    logic          sl;
    logic [IW-1:0] si;
    beats   = 0;
    cycles  = 0;
    stalled = 1'b0;
    sb      = 1'b0;
    sl      = 1'b0;
    si      = '0;
    ones    = 0;
    first   = -1;
    if (has_next) begin
      in_valid = 1'b1;
      quota_in = QW'(next_q);
    end
    while (beats < T && cycles < 2000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check_eq("beat_valid", out_valid, 1);
      if (stalled) begin
        check_eq("stall_bit", out_bit, sb);
        check_eq("stall_idx", out_idx, si);
        check_eq("stall_last", out_last, sl);
      end
      if (out_ready) begin
        check_eq("beat_idx", out_idx, beats);
        check_eq("beat_bit", out_bit, exp_bit(k, beats));
        check_eq("beat_last", out_last, beats == T - 1);
        check_eq("beat_in_ready", in_ready, beats == T - 1);
        if (out_bit) begin
          ones++;
          if (first < 0) first = beats;
        end
        beats++;
        stalled = 1'b0;
      end else begin
        check_eq("stall_in_ready", in_ready, 0);
        stalled = 1'b1;
        sb      = out_bit;
        si      = out_idx;
        sl      = out_last;
      end
      @(posedge clk);
      #0;
      if (has_next && beats == T) in_valid = 1'b0;
      #1;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_complete", beats, T);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_out_bit"}, out_bit, 0);
    check_eq({tag, "_out_idx"}, out_idx, 0);
  endtask

  // One isolated stream: quota q (model sees k), expected totals.
  task automatic run_stream(input int q, input int k, input bit rand_ready,
                            input int ones_exp, input int first_exp, input string tag);
    int ones;
    int first;
    send_quota(q);
    collect(k, rand_ready, 1'b0, 0, ones, first);
    check_eq({tag, "_ones"}, ones, ones_exp);
    check_eq({tag, "_first"}, first, first_exp);
    check_idle({tag, "_after"});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int ones;
    int first;

    rst       = 1'b1;
    in_valid  = 1'b0;
    quota_in  = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("post_reset");

    // 1: all zeros, out_last only on beat 63
    run_stream(0, 0, 1'b0, 0, -1, "q0");

    // 2: full scale and saturation
    run_stream(64, 64, 1'b0, 64, 0, "q64");
    run_stream(70, 64, 1'b0, 64, 0, "q70");

    // 3: spacing; first one at ceil(T/k)-1
    run_stream(16, 16, 1'b0, 16, exp_first(3, 16), "q16");
    run_stream(1, 1, 1'b0, 1, exp_first(63, 1), "q1");

    // 4: random backpressure must not change the sequence
    run_stream(32, 32, 1'b1, 32, exp_first(1, 32), "q32_stall");

    // 5: back-to-back streams, no bubble
    send_quota(5);
    collect(5, 1'b0, 1'b1, 9, ones, first);
    check_eq("b2b_first_ones", ones, 5);
    check_eq("b2b_first_first", first, exp_first(12, 5));
    check_eq("b2b_no_bubble_valid", out_valid, 1);
    check_eq("b2b_no_bubble_idx", out_idx, 0);
    collect(9, 1'b0, 1'b0, 0, ones, first);
    check_eq("b2b_second_ones", ones, 9);
    check_eq("b2b_second_first", first, exp_first(7, 9));
    check_idle("b2b_after");

    // 6: reset in the middle of a stream, then a clean stream
    send_quota(30);
    out_ready = 1'b1;
    repeat (20) step();
    check_eq("pre_rst_idx", out_idx, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_rst");
    run_stream(8, 8, 1'b0, 8, exp_first(7, 8), "q8_after_rst");

`ifdef STOCH_BITGEN_UNARY_EN
    // 7: thermometer stream
    run_stream(10, 10, 1'b0, 10, 0, "unary_q10");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
